ram_addr_monitor: RTL and testbench

RAM_ADDR_MONITOR -- requirements
Module: ram_addr_monitor

---
 rtl/ram_addr_monitor_if.sv | 25 ++
 rtl/ram_addr_monitor.sv | 77 +++++++
 tb/tb_ram_addr_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ram_addr_monitor_if.sv
// ram_addr_monitor_if: RAM strobe inputs and held-address display outputs of ram_addr_monitor.
interface ram_addr_monitor_if;
    logic [20:0] ram_addr_in;
    logic        ram_req;
    logic        ram_wr;
    logic        wr_only;
    logic        freeze;
    logic        clear_drops;
    logic [1:0]  cpu_speed_in;
    logic [20:0] address;
    logic [1:0]  cpu_speed;
    logic        addr_valid;
    logic        hold_active;
    logic [7:0]  drop_count;

    modport master (
        output ram_addr_in, ram_req, ram_wr, wr_only, freeze, clear_drops, cpu_speed_in,
        input  address, cpu_speed, addr_valid, hold_active, drop_count
    );

    modport slave (
        input  ram_addr_in, ram_req, ram_wr, wr_only, freeze, clear_drops, cpu_speed_in,
        output address, cpu_speed, addr_valid, hold_active, drop_count
    );
endinterface

// File: rtl/ram_addr_monitor.sv
// ram_addr_monitor: captures a qualifying RAM address and holds it for HOLD_CYCLES before the next capture.
module ram_addr_monitor #(
    parameter int HOLD_CYCLES = 50000
) (
    input logic              clk_peripheral,
    input logic              reset_n,
    ram_addr_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, READY, FROZEN} state_t;

    localparam int CW = 20;
    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [20:0]   addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [7:0]    drop_q, drop_d;
    logic          hold_q;
    logic [1:0]    sync0_q, sync1_q;
    logic          qual, drop;

    assign qual = bus.ram_req && (!bus.wr_only || bus.ram_wr);
    assign drop = qual && (bus.freeze || state_q == HOLD || state_q == FROZEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (bus.freeze) state_d = FROZEN;
        else begin
            case (state_q)
                IDLE, READY: if (qual) begin
                    state_d = HOLD;
                    cnt_d   = LOAD;
                    addr_d  = bus.ram_addr_in;
                    valid_d = 1'b1;
                end
                HOLD: if (cnt_q == '0) state_d = READY;
                      else cnt_d = cnt_q - 1'b1;
                FROZEN: state_d = valid_q ? READY : IDLE;
                default: state_d = IDLE;
            endcase
        end
        // clear wins over a coincident drop
        drop_d = bus.clear_drops ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
            hold_q  <= 1'b0;
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            hold_q  <= state_d == HOLD;
            sync0_q <= bus.cpu_speed_in;
            sync1_q <= sync0_q;
        end
    end

    assign bus.address     = addr_q;
    assign bus.addr_valid  = valid_q;
    assign bus.drop_count  = drop_q;
    assign bus.hold_active = hold_q;
    assign bus.cpu_speed   = sync1_q;
endmodule

// File: tb/tb_ram_addr_monitor.sv
// tb_ram_addr_monitor: scoreboard bench; a behavioural model pushes expected outputs, a negedge monitor compares.
module tb_ram_addr_monitor;
    localparam int HC = 4;

    typedef struct {
        int addr;
        int valid;
        int hold;
        int drops;
        int speed;
    } exp_t;

    logic clk = 0;
    logic reset_n = 0;
    ram_addr_monitor_if bus();

    ram_addr_monitor #(.HOLD_CYCLES(HC)) dut (
        .clk_peripheral(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    exp_t sb[$];

    int m_addr, m_valid, m_hold_left, m_frozen, m_drops;
    int m_hist[$];

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_valid = 0; m_hold_left = 0; m_frozen = 0; m_drops = 0;
        m_hist.delete();
    endtask

    function automatic int sat_inc(input int d);
        return d < 255 ? d + 1 : 255;
    endfunction

    // Apply one rising edge to the model using the inputs currently on the bus
    task automatic model_edge();
        exp_t e;
        bit qual = bus.ram_req && (!bus.wr_only || bus.ram_wr);
        if (bus.freeze) begin
            if (qual) m_drops = sat_inc(m_drops);
            m_frozen = 1;
            m_hold_left = 0;
        end else if (m_frozen) begin
            if (qual) m_drops = sat_inc(m_drops);
            m_frozen = 0;
        end else if (m_hold_left > 0) begin
            if (qual) m_drops = sat_inc(m_drops);
            m_hold_left--;
        end else if (qual) begin
            m_addr = int'(bus.ram_addr_in);
            m_valid = 1;
            m_hold_left = HC;
        end
        if (bus.clear_drops) m_drops = 0;
        m_hist.push_back(int'(bus.cpu_speed_in));
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        e.addr  = m_addr;
        e.valid = m_valid;
        e.hold  = (m_hold_left > 0) ? 1 : 0;
        e.drops = m_drops;
        e.speed = (m_hist.size() == 2) ? m_hist[0] : 0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        bus.ram_req = 0;
        bus.clear_drops = 0;
    endtask

    task automatic strobe(input logic wr, input logic [20:0] a);
        bus.ram_req = 1;
        bus.ram_wr = wr;
        bus.ram_addr_in = a;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string n);
        chk({n, "_addr"}, int'(bus.address), 0);
        chk({n, "_valid"}, int'(bus.addr_valid), 0);
        chk({n, "_hold"}, int'(bus.hold_active), 0);
        chk({n, "_drops"}, int'(bus.drop_count), 0);
        chk({n, "_speed"}, int'(bus.cpu_speed), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("address", int'(bus.address), e.addr);
                chk("addr_valid", int'(bus.addr_valid), e.valid);
                chk("hold_active", int'(bus.hold_active), e.hold);
                chk("drop_count", int'(bus.drop_count), e.drops);
                chk("cpu_speed", int'(bus.cpu_speed), e.speed);
            end
        end
    end

    initial begin : stim
        bus.ram_addr_in = 0; bus.ram_req = 0; bus.ram_wr = 0; bus.wr_only = 0;
        bus.freeze = 0; bus.clear_drops = 0; bus.cpu_speed_in = 0;
        model_reset();
        #2 check_all_zero("reset");
        #10 reset_n = 1;
        idle(2);
        strobe(1, 21'h1ABCD);
        idle(6);
        strobe(0, 21'h00010);
        idle(1);
        strobe(1, 21'h00020);
        idle(3);
        strobe(0, 21'h00030);
        idle(5);
        bus.wr_only = 1;
        strobe(0, 21'h0FFFF);
        strobe(1, 21'h01234);
        idle(5);
        bus.wr_only = 0;
        bus.freeze = 1;
        strobe(1, 21'h00055);
        for (int i = 0; i < 300; i++) strobe(i[0], 21'($urandom));
        bus.freeze = 0;
        tick();
        strobe(1, 21'h00077);
        idle(2);
        bus.clear_drops = 1;
        strobe(1, 21'h00099);
        idle(4);
        bus.cpu_speed_in = 3;
        idle(4);
        bus.freeze = 1;
        tick();
        bus.cpu_speed_in = 1;
        idle(3);
        bus.cpu_speed_in = 2;
        idle(3);
        bus.freeze = 0;
        idle(2);
        strobe(0, 21'h00ABC);
        tick();
        #6 reset_n = 0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #3 reset_n = 1;
        strobe(1, 21'h12345);
        idle(5);
        for (int i = 0; i < 3000; i++) begin
            bus.freeze = ($urandom_range(0, 29) == 0) ? 1'b1 : (bus.freeze && $urandom_range(0, 3) != 0);
            bus.wr_only = ($urandom_range(0, 49) == 0) ? ~bus.wr_only : bus.wr_only;
            bus.clear_drops = ($urandom_range(0, 39) == 0);
            bus.cpu_speed_in = 2'($urandom);
            bus.ram_req = ($urandom_range(0, 2) == 0);
            bus.ram_wr = 1'($urandom);
            bus.ram_addr_in = 21'($urandom);
            tick();
        end
        bus.freeze = 0;
        idle(3);
        #20 chk("scoreboard_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
